// File: rtl/cordic_shift_seq.sv
// Per-iteration shift-amount sequencer for the iterative CORDIC datapath.
// Generates circular/hyperbolic shift counts, including hyperbolic repeats, paced by adv_i.
module cordic_shift_seq #(
    parameter  int W    = 5,
    parameter  int ITER = 32,
    localparam int IW   = $clog2(ITER)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          mode_i,
    input  logic          adv_i,
    input  logic          abort_i,
    output logic          busy_o,
    output logic [W-1:0]  shift_o,
    output logic [IW-1:0] idx_o,
    output logic          repeat_o,
    output logic          last_o,
    output logic          done_o
);
    // state  | meaning
    // S_IDLE | waiting for start_i; all iteration outputs held at 0
    // S_RUN  | presenting one iteration entry, advancing on adv_i

    localparam int           NW        = W + 2;
    localparam logic [W-1:0] SHIFT_MAX = {W{1'b1}};
    localparam logic [NW-1:0] NR_INIT  = NW'(4);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t         state_q;
    logic           mode_q;
    logic           busy_q;
    logic [W-1:0]   shift_q, shift_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic           repeat_q, repeat_d;
    logic           last_q, last_d;
    logic           done_q;
    logic [NW-1:0]  nr_q, nr_d;
    logic           rpt_hit;

    // Next entry assuming an advance that is not the final one.
    always_comb begin
        idx_d    = idx_q + IW'(1);
        last_d   = (idx_q == IW'(ITER - 2));
        shift_d  = shift_q;
        repeat_d = 1'b0;
        nr_d     = nr_q;
        rpt_hit  = mode_q && !repeat_q && (shift_q != SHIFT_MAX) &&
                   ({2'b00, shift_q} == nr_q);
        if (rpt_hit) begin
            repeat_d = 1'b1;
            nr_d     = nr_q + (nr_q << 1) + NW'(1);
        end else if (shift_q != SHIFT_MAX) begin
            shift_d = shift_q + W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= S_IDLE;
            mode_q   <= 1'b0;
            busy_q   <= 1'b0;
            shift_q  <= '0;
            idx_q    <= '0;
            repeat_q <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            nr_q     <= NR_INIT;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        state_q  <= S_RUN;
                        mode_q   <= mode_i;
                        busy_q   <= 1'b1;
                        shift_q  <= mode_i ? W'(1) : '0;
                        idx_q    <= '0;
                        repeat_q <= 1'b0;
                        last_q   <= 1'b0;
                        nr_q     <= NR_INIT;
                    end
                end
                S_RUN: begin
                    if (abort_i || (adv_i && last_q)) begin
                        state_q  <= S_IDLE;
                        busy_q   <= 1'b0;
                        shift_q  <= '0;
                        idx_q    <= '0;
                        repeat_q <= 1'b0;
                        last_q   <= 1'b0;
                        nr_q     <= NR_INIT;
                        done_q   <= !abort_i;
                    end else if (adv_i) begin
                        shift_q  <= shift_d;
                        idx_q    <= idx_d;
                        repeat_q <= repeat_d;
                        last_q   <= last_d;
                        nr_q     <= nr_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy_o   = busy_q;
    assign shift_o  = shift_q;
    assign idx_o    = idx_q;
    assign repeat_o = repeat_q;
    assign last_o   = last_q;
    assign done_o   = done_q;

endmodule

// File: tb/tb_cordic_shift_seq.sv
// Directed bench for cordic_shift_seq: four parameterisations sharing one clock.
module tb_cordic_shift_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // A: hyperbolic/circular, W=5 ITER=32
    logic a_rst, a_start, a_mode, a_adv, a_abort, a_busy, a_rep, a_last, a_done;
    logic [4:0] a_shift, a_idx;
    cordic_shift_seq #(.W(5), .ITER(32)) u_a (
        .clk_i(clk), .rst_n_i(a_rst), .start_i(a_start), .mode_i(a_mode), .adv_i(a_adv),
        .abort_i(a_abort), .busy_o(a_busy), .shift_o(a_shift), .idx_o(a_idx),
        .repeat_o(a_rep), .last_o(a_last), .done_o(a_done));

    // B: circular, W=5 ITER=16
    logic b_rst, b_start, b_mode, b_adv, b_abort, b_busy, b_rep, b_last, b_done;
    logic [4:0] b_shift;
    logic [3:0] b_idx;
    cordic_shift_seq #(.W(5), .ITER(16)) u_b (
        .clk_i(clk), .rst_n_i(b_rst), .start_i(b_start), .mode_i(b_mode), .adv_i(b_adv),
        .abort_i(b_abort), .busy_o(b_busy), .shift_o(b_shift), .idx_o(b_idx),
        .repeat_o(b_rep), .last_o(b_last), .done_o(b_done));

    // C: hyperbolic, W=6 ITER=48
    logic c_rst, c_start, c_mode, c_adv, c_abort, c_busy, c_rep, c_last, c_done;
    logic [5:0] c_shift, c_idx;
    cordic_shift_seq #(.W(6), .ITER(48)) u_c (
        .clk_i(clk), .rst_n_i(c_rst), .start_i(c_start), .mode_i(c_mode), .adv_i(c_adv),
        .abort_i(c_abort), .busy_o(c_busy), .shift_o(c_shift), .idx_o(c_idx),
        .repeat_o(c_rep), .last_o(c_last), .done_o(c_done));

    // D: circular, W=3 ITER=10
    logic d_rst, d_start, d_mode, d_adv, d_abort, d_busy, d_rep, d_last, d_done;
    logic [2:0] d_shift;
    logic [3:0] d_idx;
    cordic_shift_seq #(.W(3), .ITER(10)) u_d (
        .clk_i(clk), .rst_n_i(d_rst), .start_i(d_start), .mode_i(d_mode), .adv_i(d_adv),
        .abort_i(d_abort), .busy_o(d_busy), .shift_o(d_shift), .idx_o(d_idx),
        .repeat_o(d_rep), .last_o(d_last), .done_o(d_done));

    // Hand-derived hyperbolic table for W=5 ITER=32.
    function automatic int hyp_shift(input int i);
        if (i < 4)       return i + 1;
        else if (i == 4) return 4;
        else if (i < 14) return i;
        else if (i == 14) return 13;
        else             return i - 1;
    endfunction

    initial begin
        int bi;
        int fin;
        {a_rst, a_start, a_mode, a_adv, a_abort} = '0;
        {b_rst, b_start, b_mode, b_adv, b_abort} = '0;
        {c_rst, c_start, c_mode, c_adv, c_abort} = '0;
        {d_rst, d_start, d_mode, d_adv, d_abort} = '0;
        repeat (2) @(negedge clk);
        {a_rst, b_rst, c_rst, d_rst} = 4'b1111;

        chk("rst_busy", a_busy, 0);
        chk("rst_shift", a_shift, 0);
        chk("rst_idx", a_idx, 0);
        chk("rst_rep", a_rep, 0);
        chk("rst_last", a_last, 0);
        chk("rst_done", a_done, 0);

        // ABORT in IDLE has no effect, START then launches normally
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        chk("idle_abort_busy", a_busy, 0);

        // Hyperbolic full run, ADV held high; START in final-ADV cycle is ignored
        a_start = 1'b1; a_mode = 1'b1; a_adv = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            chk("hyp_busy", a_busy, 1);
            chk("hyp_idx", a_idx, i);
            chk("hyp_shift", a_shift, hyp_shift(i));
            chk("hyp_rep", a_rep, (i == 4 || i == 14) ? 1 : 0);
            chk("hyp_last", a_last, (i == 31) ? 1 : 0);
            chk("hyp_done", a_done, 0);
            if (i == 31) begin a_start = 1'b1; a_mode = 1'b0; end
            @(negedge clk);
        end
        chk("hyp_done_pulse", a_done, 1);
        chk("hyp_end_busy", a_busy, 0);
        chk("hyp_end_idx", a_idx, 0);
        chk("hyp_end_shift", a_shift, 0);
        chk("hyp_end_last", a_last, 0);
        // START held into the DONE cycle is accepted there
        @(negedge clk);
        a_start = 1'b0;
        chk("done_once", a_done, 0);
        chk("restart_busy", a_busy, 1);
        chk("restart_idx", a_idx, 0);
        chk("restart_shift", a_shift, 0);

        // Circular run: START mid-run ignored, ABORT with ADV at IDX 5
        for (int i = 0; i < 6; i++) begin
            chk("abr_idx", a_idx, i);
            chk("abr_shift", a_shift, i);
            chk("abr_rep", a_rep, 0);
            if (i == 2) begin a_start = 1'b1; a_mode = 1'b1; end
            if (i == 3) a_start = 1'b0;
            if (i == 5) a_abort = 1'b1;
            @(negedge clk);
        end
        a_abort = 1'b0; a_adv = 1'b0;
        chk("abr_busy", a_busy, 0);
        chk("abr_idx0", a_idx, 0);
        chk("abr_shift0", a_shift, 0);
        chk("abr_done", a_done, 0);
        @(negedge clk);
        chk("abr_done2", a_done, 0);
        chk("abr_busy2", a_busy, 0);

        // Reset mid-run at IDX 20
        a_start = 1'b1; a_mode = 1'b1; a_adv = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        for (int i = 0; i < 21; i++) begin
            chk("rr_idx", a_idx, i);
            if (i == 20) a_rst = 1'b0;
            @(negedge clk);
        end
        a_rst = 1'b1; a_adv = 1'b0;
        chk("rr_busy", a_busy, 0);
        chk("rr_shift", a_shift, 0);
        chk("rr_idx0", a_idx, 0);
        chk("rr_rep", a_rep, 0);
        chk("rr_last", a_last, 0);
        chk("rr_done", a_done, 0);
        @(negedge clk);
        chk("rr_done2", a_done, 0);
        // Next-repeat register must be back at 4 after reset
        a_start = 1'b1; a_mode = 1'b1; a_adv = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        repeat (4) @(negedge clk);
        chk("rr_nr_idx", a_idx, 4);
        chk("rr_nr_shift", a_shift, 4);
        chk("rr_nr_rep", a_rep, 1);
        a_abort = 1'b1; a_adv = 1'b0;
        @(negedge clk);
        a_abort = 1'b0;

        // B: circular with random ADV gaps
        b_start = 1'b1; b_mode = 1'b0;
        @(negedge clk);
        b_start = 1'b0;
        bi = 0; fin = 0;
        for (int c = 0; c < 300; c++) begin
            if (bi == 16) begin
                chk("b_done", b_done, 1);
                chk("b_end_busy", b_busy, 0);
                fin = 1;
                break;
            end
            chk("b_done_low", b_done, 0);
            chk("b_busy", b_busy, 1);
            chk("b_idx", b_idx, bi);
            chk("b_shift", b_shift, bi);
            chk("b_rep", b_rep, 0);
            chk("b_last", b_last, (bi == 15) ? 1 : 0);
            b_adv = 1'($urandom_range(0, 1));
            if (b_adv) bi++;
            @(negedge clk);
        end
        b_adv = 1'b0;
        chk("b_finished", fin, 1);
        @(negedge clk);
        chk("b_done_once", b_done, 0);

        // C: hyperbolic W=6 ITER=48, third repeat at 40
        c_start = 1'b1; c_mode = 1'b1; c_adv = 1'b1;
        @(negedge clk);
        c_start = 1'b0;
        for (int i = 0; i < 48; i++) begin
            chk("c_idx", c_idx, i);
            if (i == 41) begin chk("c41_shift", c_shift, 40); chk("c41_rep", c_rep, 0); end
            if (i == 42) begin chk("c42_shift", c_shift, 40); chk("c42_rep", c_rep, 1); end
            if (i == 47) begin chk("c47_shift", c_shift, 45); chk("c47_last", c_last, 1); end
            @(negedge clk);
        end
        c_adv = 1'b0;
        chk("c_done", c_done, 1);

        // D: circular W=3 ITER=10, saturation at 7
        d_start = 1'b1; d_mode = 1'b0; d_adv = 1'b1;
        @(negedge clk);
        d_start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk("d_idx", d_idx, i);
            chk("d_shift", d_shift, (i < 7) ? i : 7);
            chk("d_done_low", d_done, 0);
            @(negedge clk);
        end
        d_adv = 1'b0;
        chk("d_done", d_done, 1);
        chk("d_busy", d_busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
